// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder/subtractor controller:
// state encoding, default operand width and counter sizing.
package serial_add_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  // Bits needed to count from 0 to w-1; at least one bit.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/serial_add_ctrl_full_adder.sv
// One-bit full adder cell, the only arithmetic element the serial
// controller steps across the operand bits.
module Full_adder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (c & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller: accepts an operand pair, feeds one bit
// per clock (LSB first) through a single full adder, then presents the result.
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] shift_a;
  logic [WIDTH-1:0] shift_b;
  logic             carry;
  logic [CW-1:0]    count;
  logic             fa_sum;
  logic             fa_carry;

  Full_adder u_fa (
    .a     (shift_a[0]),
    .b     (shift_b[0]),
    .c     (carry),
    .sum   (fa_sum),
    .carry (fa_carry)
  );

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Subtraction is folded into the load: B is inverted and the carry forced to 1.
  // On the last step the stored carry is the carry into the MSB.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      shift_a <= '0;
      shift_b <= '0;
      carry   <= 1'b0;
      count   <= '0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            shift_a <= a;
            shift_b <= op_sub ? ~b : b;
            carry   <= op_sub ? 1'b1 : cin;
            count   <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          sum     <= {fa_sum, sum[WIDTH-1:1]};
          carry   <= fa_carry;
          shift_a <= {1'b0, shift_a[WIDTH-1:1]};
          shift_b <= {1'b0, shift_b[WIDTH-1:1]};
          if (count == LAST) begin
            cout  <= fa_carry;
            ovf   <= carry ^ fa_carry;
            state <= DONE;
          end else begin
            count <= count + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl at WIDTH=8: directed cases,
// backpressure, mid-run reset and randomized operations against a reference.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         op_sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int tests = 0;
  int fails = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .op_sub    (op_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer arithmetic, overflow from operand/result signs.
  function automatic logic [W+1:0] refModel(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                            input logic rcin, input logic rsub);
    logic [W-1:0] bb;
    logic [W:0]   full;
    logic         v;
    bb   = rsub ? ~rb : rb;
    full = {1'b0, ra} + {1'b0, bb} + {{W{1'b0}}, (rsub ? 1'b1 : rcin)};
    v    = (ra[W-1] == bb[W-1]) && (full[W-1] != ra[W-1]);
    return {v, full[W], full[W-1:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present an operand pair in IDLE and complete the input handshake.
  task automatic applyStimulus(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                               input logic tcin, input logic tsub);
    a        = ta;
    b        = tb;
    cin      = tcin;
    op_sub   = tsub;
    in_valid = 1'b1;
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Wait (bounded) for out_valid and check it arrives W edges after acceptance.
  // With noisy set, random operands are pulsed while the controller is busy.
  task automatic waitResult(input string tag, input bit noisy);
    int lat;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      if (noisy) begin
        check({tag, "_busy_in_ready"}, {31'd0, in_ready}, 32'd0);
        in_valid = 1'($urandom_range(0, 1));
        a        = W'($urandom);
        b        = W'($urandom);
        op_sub   = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    check({tag, "_latency"}, lat, W);
  endtask

  // Compare the presented result, then drain it and confirm return to IDLE.
  task automatic checkOutput(input string tag, input logic [W-1:0] es, input logic ec, input logic eo);
    check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_sum"}, {24'd0, sum}, {24'd0, es});
    check({tag, "_cout"}, {31'd0, cout}, {31'd0, ec});
    check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, eo});
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_idle_in_ready"}, {31'd0, in_ready}, 32'd1);
    check({tag, "_idle_out_valid"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    logic [W+1:0] exp;
    logic [W-1:0] ra, rb;
    logic         rc, rs;
    bit           sawValid;

    rst_n     = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    a         = 8'hAA;
    b         = 8'h55;
    cin       = 1'b0;
    op_sub    = 1'b0;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_sum", {24'd0, sum}, 32'd0);
    check("reset_cout", {31'd0, cout}, 32'd0);
    check("reset_ovf", {31'd0, ovf}, 32'd0);
    @(negedge clk);
    check("reset_still_idle", {31'd0, in_ready}, 32'd1);

    applyStimulus("add_ovf", 8'h5A, 8'h3C, 1'b0, 1'b0);
    waitResult("add_ovf", 1'b0);
    checkOutput("add_ovf", 8'h96, 1'b0, 1'b1);

    applyStimulus("wrap1", 8'hFF, 8'h01, 1'b0, 1'b0);
    waitResult("wrap1", 1'b0);
    checkOutput("wrap1", 8'h00, 1'b1, 1'b0);

    applyStimulus("wrap2", 8'hFF, 8'hFF, 1'b1, 1'b0);
    waitResult("wrap2", 1'b0);
    checkOutput("wrap2", 8'hFF, 1'b1, 1'b0);

    applyStimulus("sub_borrow", 8'h10, 8'h20, 1'b1, 1'b1);
    waitResult("sub_borrow", 1'b0);
    checkOutput("sub_borrow", 8'hF0, 1'b0, 1'b0);

    applyStimulus("sub_ovf", 8'h80, 8'h01, 1'b0, 1'b1);
    waitResult("sub_ovf", 1'b0);
    checkOutput("sub_ovf", 8'h7F, 1'b1, 1'b1);

    // Backpressure with ignored inputs during RUN and DONE.
    applyStimulus("bp", 8'h33, 8'h44, 1'b1, 1'b0);
    waitResult("bp", 1'b1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'(i % 2);
      a        = W'($urandom);
      b        = W'($urandom);
      @(negedge clk);
      check($sformatf("bp_hold%0d_out_valid", i), {31'd0, out_valid}, 32'd1);
      check($sformatf("bp_hold%0d_in_ready", i), {31'd0, in_ready}, 32'd0);
      check($sformatf("bp_hold%0d_sum", i), {24'd0, sum}, 32'h78);
      check($sformatf("bp_hold%0d_cout", i), {31'd0, cout}, 32'd0);
      check($sformatf("bp_hold%0d_ovf", i), {31'd0, ovf}, 32'd0);
    end
    in_valid = 1'b0;
    checkOutput("bp", 8'h78, 1'b0, 1'b0);
    sawValid = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid !== 1'b0) sawValid = 1'b1;
    end
    check("bp_no_phantom_result", {31'd0, sawValid}, 32'd0);

    // Reset lands on the third RUN edge.
    applyStimulus("rst_mid", 8'h7F, 8'h01, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_mid_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_mid_sum", {24'd0, sum}, 32'd0);
    sawValid = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid !== 1'b0) sawValid = 1'b1;
    end
    check("rst_mid_no_result", {31'd0, sawValid}, 32'd0);
    applyStimulus("after_rst", 8'h01, 8'h02, 1'b0, 1'b0);
    waitResult("after_rst", 1'b0);
    checkOutput("after_rst", 8'h03, 1'b0, 1'b0);

    // Randomized operations against the reference model, random consumer stall.
    for (int i = 0; i < 20; i++) begin
      ra  = W'($urandom);
      rb  = W'($urandom);
      rc  = 1'($urandom_range(0, 1));
      rs  = 1'($urandom_range(0, 1));
      exp = refModel(ra, rb, rc, rs);
      applyStimulus($sformatf("rand%0d", i), ra, rb, rc, rs);
      waitResult($sformatf("rand%0d", i), 1'b0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      checkOutput($sformatf("rand%0d", i), exp[W-1:0], exp[W], exp[W+1]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
